// File: rtl/key_switch_conditioner.sv
// Push-button conditioner: synchronise, debounce and toggle a switch level for the lamp FSM.
// Optional LONG_PRESS_OFF_EN adds a hold counter that forces fake_switch low on a long press.
module key_switch_conditioner #(
  parameter int unsigned DEB_CYCLES     = 200,
  parameter int unsigned LONG_CYCLES    = 20000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic Div_CLK,
  input  logic Sys_RST,
  input  logic Key,
  output logic fake_switch,
  output logic key_level,
  output logic press_pulse,
  output logic long_press
);

  localparam int unsigned    DebW        = $clog2(DEB_CYCLES + 1);
  localparam logic [DebW-1:0] DebLast    = DebW'(DEB_CYCLES - 1);
  localparam logic           RawReleased = KEY_ACTIVE_LOW;

  // Synchroniser, preset to the released raw level so reset never looks like a press.
  logic sync1_q;
  logic sync2_q;
  logic key_s;

  always_ff @(posedge Div_CLK) begin
    if (Sys_RST) begin
      sync1_q <= RawReleased;
      sync2_q <= RawReleased;
    end else begin
      sync1_q <= Key;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q ^ KEY_ACTIVE_LOW;

  logic [DebW-1:0] deb_cnt_q;
  logic [DebW-1:0] deb_cnt_d;
  logic            level_q;
  logic            level_d;
  logic            flip;
  logic            rise;
  logic            fall;

  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    flip      = 1'b0;
    if (key_s != level_q) begin
      if (deb_cnt_q == DebLast) begin
        flip    = 1'b1;
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  assign rise = flip & ~level_q;
  assign fall = flip & level_q;

  always_ff @(posedge Div_CLK) begin
    if (Sys_RST) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

`ifdef LONG_PRESS_OFF_EN
  typedef enum logic [1:0] {StReleased, StPressed, StLocked} state_e;

  localparam int unsigned      HoldW    = $clog2(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic [HoldW-1:0] hold_q;
  logic [HoldW-1:0] hold_d;
  logic             long_q;
  logic             long_d;
`else
  typedef enum logic {StReleased, StPressed} state_e;
`endif

  state_e state_q;
  state_e state_d;
  logic   fake_q;
  logic   fake_d;
  logic   press_q;
  logic   press_d;

  always_comb begin
    state_d = state_q;
    fake_d  = fake_q;
    press_d = 1'b0;
`ifdef LONG_PRESS_OFF_EN
    hold_d  = hold_q;
    long_d  = 1'b0;
`endif
    case (state_q)
      StReleased: begin
        if (rise) begin
          state_d = StPressed;
          fake_d  = ~fake_q;
          press_d = 1'b1;
`ifdef LONG_PRESS_OFF_EN
          hold_d  = '0;
`endif
        end
      end
      StPressed: begin
        // A release on the threshold edge wins over the long press.
        if (fall) begin
          state_d = StReleased;
`ifdef LONG_PRESS_OFF_EN
        end else if (hold_q == HoldLast) begin
          state_d = StLocked;
          fake_d  = 1'b0;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HoldW'(1);
`endif
        end
      end
`ifdef LONG_PRESS_OFF_EN
      StLocked: begin
        if (fall) begin
          state_d = StReleased;
        end
      end
`endif
      default: state_d = StReleased;
    endcase
  end

  always_ff @(posedge Div_CLK) begin
    if (Sys_RST) begin
      state_q <= StReleased;
      fake_q  <= 1'b0;
      press_q <= 1'b0;
`ifdef LONG_PRESS_OFF_EN
      hold_q  <= '0;
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fake_q  <= fake_d;
      press_q <= press_d;
`ifdef LONG_PRESS_OFF_EN
      hold_q  <= hold_d;
      long_q  <= long_d;
`endif
    end
  end

  assign fake_switch = fake_q;
  assign key_level   = level_q;
  assign press_pulse = press_q;
`ifdef LONG_PRESS_OFF_EN
  assign long_press  = long_q;
`else
  assign long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_key_switch_conditioner.sv
// Bench for key_switch_conditioner: directed plan plus random key/reset stimulus,
// checked every cycle against a window-based behavioural model.
module tb_key_switch_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam bit          AL   = 1'b1;

  logic clk;
  logic rst;
  logic key;
  logic fake_switch;
  logic key_level;
  logic press_pulse;
  logic long_press;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press  = 0;
  int n_long   = 0;

  key_switch_conditioner #(
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LONG),
    .KEY_ACTIVE_LOW(AL)
  ) dut (
    .Div_CLK    (clk),
    .Sys_RST    (rst),
    .Key        (key),
    .fake_switch(fake_switch),
    .key_level  (key_level),
    .press_pulse(press_pulse),
    .long_press (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level flips once the last DEB synchronised samples all disagree with it.
  bit m_pipe0, m_pipe1;
  bit win[$];
  bit m_level, m_fake, m_press, m_long, m_locked;
  int m_since;

  always @(posedge clk) begin
    if (rst) begin
      m_pipe0 = AL;
      m_pipe1 = AL;
      win.delete();
      m_level  = 1'b0;
      m_fake   = 1'b0;
      m_press  = 1'b0;
      m_long   = 1'b0;
      m_locked = 1'b0;
      m_since  = 0;
    end else begin
      bit ks;
      bit flip;
      ks = m_pipe1 ^ AL;
      win.push_back(ks);
      if (win.size() > DEB) void'(win.pop_front());
      flip = (win.size() == DEB);
      foreach (win[i]) if (win[i] == m_level) flip = 1'b0;
      m_press = 1'b0;
      m_long  = 1'b0;
      if (flip) begin
        m_level = ~m_level;
        if (m_level) begin
          m_fake   = ~m_fake;
          m_press  = 1'b1;
          m_since  = 0;
          m_locked = 1'b0;
        end
      end else if (m_level) begin
        m_since++;
`ifdef LONG_PRESS_OFF_EN
        if (!m_locked && m_since == LONG) begin
          m_locked = 1'b1;
          m_fake   = 1'b0;
          m_long   = 1'b1;
        end
`endif
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = key;
    end
  end

  always @(negedge clk) begin
    chk("fake_switch", fake_switch, m_fake);
    chk("key_level", key_level, m_level);
    chk("press_pulse", press_pulse, m_press);
    chk("long_press", long_press, m_long);
    if (press_pulse === 1'b1) n_press++;
    if (long_press === 1'b1) n_long++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic k);
    rst = 1'b1;
    key = k;
    cyc(3);
    chk("rst_fake", fake_switch, 1'b0);
    chk("rst_level", key_level, 1'b0);
    chk("rst_press", press_pulse, 1'b0);
    chk("rst_long", long_press, 1'b0);
    rst = 1'b0;
  endtask

  // Press from idle: level rises after edge DEB+1, with a single pulse.
  task automatic press_check(input logic exp_fake);
    key = 1'b0;
    cyc(DEB + 1);
    chk("pre_level", key_level, 1'b0);
    cyc(1);
    chk("press_level", key_level, 1'b1);
    chk("press_fake", fake_switch, exp_fake);
    chk("press_pulse_on", press_pulse, 1'b1);
    cyc(1);
    chk("press_pulse_off", press_pulse, 1'b0);
  endtask

  int p0;
  int l0;
  logic tap_exp[3];

  initial begin
    rst = 1'b1;
    key = 1'b1;

    // Key held pressed through reset is a new press.
    do_reset(1'b0);
    press_check(1'b1);
    key = 1'b1;
    cyc(10);

    // Clean press then release.
    do_reset(1'b1);
    press_check(1'b1);
    cyc(3);
    key = 1'b1;
    cyc(8);
    chk("release_level", key_level, 1'b0);
    chk("release_fake", fake_switch, 1'b1);

    // Bounce rejection.
    p0 = n_press;
    key = 1'b0; cyc(3);
    key = 1'b1; cyc(1);
    key = 1'b0; cyc(3);
    key = 1'b1; cyc(10);
    chk_int("bounce_pulses", n_press - p0, 0);
    chk("bounce_level", key_level, 1'b0);
    chk("bounce_fake", fake_switch, 1'b1);

    // Three taps.
    do_reset(1'b1);
    p0 = n_press;
    tap_exp[0] = 1'b1;
    tap_exp[1] = 1'b0;
    tap_exp[2] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      key = 1'b0;
      cyc(8);
      chk("tap_fake", fake_switch, tap_exp[t]);
      key = 1'b1;
      cyc(8);
    end
    chk_int("tap_pulses", n_press - p0, 3);

    // Long press starting with fake_switch = 1.
    l0 = n_long;
    key = 1'b0;
    cyc(30);
    key = 1'b1;
    cyc(10);
`ifdef LONG_PRESS_OFF_EN
    chk_int("long_pulses", n_long - l0, 1);
`else
    chk_int("long_pulses", n_long - l0, 0);
`endif
    chk("long_fake", fake_switch, 1'b0);

    // Reset in the middle of debouncing a press.
    key = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_level", key_level, 1'b0);
    chk("mid_rst_fake", fake_switch, 1'b0);
    rst = 1'b0;
    p0 = n_press;
    cyc(3);
    key = 1'b1;
    cyc(10);
    chk_int("mid_rst_pulses", n_press - p0, 0);
    chk("mid_rst_fake_end", fake_switch, 1'b0);

    // Random key runs with occasional resets.
    repeat (200) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      key = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) cyc($urandom_range(20, 40));
      else cyc($urandom_range(1, 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_switch_conditioner.md
Name: key_switch_conditioner

Overview:
- Upstream stage of the three-colour lamp controller.
- Converts one raw, bouncing push button into the clean `fake_switch` level that the lamp FSM consumes.
- Each debounced press toggles `fake_switch`; a long hold forces the lamp off.
- Runs on the same divided clock as the lamp FSM (10 kHz nominal, so 10000 cycles = 1 s).

Parameters:
- DEB_CYCLES, 200, consecutive stable cycles required to accept a key level change (20 ms at 10 kHz); must be >= 1.
- LONG_CYCLES, 20000, cycles a debounced press must be held to count as a long press (2 s); must be > DEB_CYCLES.
- KEY_ACTIVE_LOW, 1, 1: raw key reads 0 when pressed; 0: reads 1 when pressed.

Ports:
- Div_CLK  input  1  divided system clock; all logic on its rising edge.
- Sys_RST  input  1  reset; synchronous, active-high.
- Key  input  1  raw asynchronous push-button level.
- fake_switch  output  1  conditioned switch level to the lamp FSM.
- key_level  output  1  debounced key state, 1 = pressed, independent of KEY_ACTIVE_LOW.
- press_pulse  output  1  one-cycle pulse on each accepted press.
- long_press  output  1  one-cycle pulse when a long press is recognised.

Behaviour:
- **Clock and reset.** One clock (Div_CLK); reset Sys_RST is synchronous and active-high.
- **Reset values.**
  - fake_switch, key_level, press_pulse and long_press are all 0.
  - Both synchroniser flops are preset to the released raw level.
  - Debounce counter and hold counter are 0; FSM is in RELEASED.
  - Reset asserted mid-press or mid-debounce discards all progress.
- **Synchroniser.**
  - Two flops; Key is first sampled at edge 0 and is visible as key_s after edge 1.
  - key_s is normalised to pressed = 1 using KEY_ACTIVE_LOW.
- **Debounce.**
  - A counter of width $clog2(DEB_CYCLES+1) increments on each edge where key_s differs from key_level.
  - On any edge where key_s equals key_level, the counter clears, so a glitch shorter than DEB_CYCLES cycles causes no change.
  - On the edge where a mismatch persists with count == DEB_CYCLES-1, key_level flips and the counter clears.
  - Latency: a clean raw transition before edge 0 changes key_level after edge DEB_CYCLES+1.
- **FSM (states RELEASED, PRESSED, LOCKED).**
  - RELEASED -> PRESSED on the edge key_level rises:
    - fake_switch toggles on that same edge;
    - press_pulse = 1 for exactly that cycle;
    - the hold counter clears.
  - PRESSED:
    - the hold counter increments each edge while key_level = 1;
    - when the hold counter == LONG_CYCLES-1, go to LOCKED, force fake_switch = 0, and pulse long_press for one cycle;
    - key_level falling goes to RELEASED with no output change.
  - LOCKED:
    - all further hold time is ignored and the hold counter saturates;
    - key_level falling goes to RELEASED.
  - Releasing never toggles fake_switch.
- **Counter widths.** The hold counter is $clog2(LONG_CYCLES) bits and never wraps.
- **Simultaneous events.**
  - Reset has priority over every event.
  - A long-press threshold and a release on the same edge: release wins, with no long_press pulse.
- **Key held through reset deassertion.** The key is synchronised and debounced from the released preset and is treated as a new press (fake_switch toggles to 1).
- **Output registering.** All outputs are registered with no combinational path from Key; fake_switch is stable between accepted events.

Optional Feature:
- Macro: LONG_PRESS_OFF_EN.
- When defined: PRESSED/LOCKED long-press handling exactly as above.
- When undefined:
  - the hold counter and LOCKED state are removed;
  - long_press is tied to 0;
  - a held key stays in PRESSED until release;
  - fake_switch changes only on press toggles.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, KEY_ACTIVE_LOW=1):
- **Reset:** Sys_RST high 3 cycles with Key=0 -> all outputs 0 during reset. After deassert: key_level=1 after 6 edges, fake_switch=1, press_pulse high for exactly 1 cycle.
- **Clean press:** Key 1->0 before edge 0, held 10 cycles, then released -> key_level=1 and fake_switch 0->1 after edge 5, press_pulse for 1 cycle. After release, key_level=0 following debounce and fake_switch stays 1.
- **Bounce rejection:** Key pulses low for 3 cycles, high 1 cycle, low 3 cycles, then high -> key_level, fake_switch and press_pulse never change.
- **Three taps, each 8 cycles low with 8 cycles high between:** fake_switch sequence 0->1->0->1 and 3 press_pulses.
- **Long press with fake_switch=1:** hold Key low 30 cycles -> fake_switch=0 and one long_press pulse 20 cycles after key_level rises, no further pulses, nothing on release. With LONG_PRESS_OFF_EN undefined: fake_switch toggles once at the press, then stays put and long_press stays 0.
- **Mid-debounce reset:** assert Sys_RST at debounce count 2 -> counter 0 and outputs 0 next cycle; no toggle occurs if Key is released before 4 stable cycles after reset.
